// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the serial-RAM target: command opcodes,
// phase lengths and the FSM state encoding.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int CMD_BITS        = 8;
    localparam int ADDR_PHASE_BITS = 24;
    localparam int DUMMY_BITS      = 8;

    // Counter values on the rise that completes each phase
    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_PHASE_BITS - 1);
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);
    localparam logic [4:0] BYTE_LAST  = 5'd7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_DUMMY   = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_WR_DATA = 3'd5;
    localparam logic [2:0] ST_IGNORE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CMD     = ST_CMD,
        S_ADDR    = ST_ADDR,
        S_DUMMY   = ST_DUMMY,
        S_RD_DATA = ST_RD_DATA,
        S_WR_DATA = ST_WR_DATA,
        S_IGNORE  = ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ      = 2'd0,
        OP_WRITE     = 2'd1,
        OP_FAST_READ = 2'd2
    } op_t;

endpackage

// File: rtl/spi_ram_target_if.sv
// SPI pin bundle between an initiator (master) and the RAM target (slave).
interface spi_ram_target_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_clk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_in_sync.sv
// Brings the three asynchronous SPI pins into the clk domain. sclk gets one
// extra flop after the synchronizer so rise/fall pulses are derived only from
// settled values; cs_n and mosi are delivered as levels aligned with sclk.
// SYNC_STAGES must be at least 2.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic cs_n_in,
    input  logic mosi_in,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_d;

    // Synchronizer chains; cs_n resets to deasserted so reset looks like idle bus
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_n_q <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_in};
            cs_n_q <= {cs_n_q[SYNC_STAGES-2:0], cs_n_in};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_in};
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
    assign cs_n_s    = cs_n_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_ram_target.sv
// Mode-0 SPI responder emulating a serial RAM (READ 0x03, WRITE 0x02, 24-bit
// address, MSB first) backed by a 2**ADDR_BITS byte array.
// Optional feature: define SPI_RAM_TARGET_FAST_READ_EN to accept FAST READ
// (0x0B) with 8 dummy clocks; otherwise 0x0B is an unknown command.
//
// Write-event strobe: wr_evt is high for exactly one clk per committed byte;
// wr_evt_addr / wr_evt_data are meaningful only in that cycle. There is no
// back-pressure, so an observer must take the event in the cycle it appears.
module spi_ram_target
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_target_if.slave      spi,
    output logic                 busy,
    output logic                 wr_evt,
    output logic [ADDR_BITS-1:0] wr_evt_addr,
    output logic [7:0]           wr_evt_data,
    output logic [2:0]           dbg_state
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Shift register wide enough for the command byte and the kept address bits
    localparam int SHW   = (ADDR_BITS > CMD_BITS) ? ADDR_BITS : CMD_BITS;

    logic sclk_rise, sclk_fall, cs_n_s, mosi_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (spi.spi_clk),
        .cs_n_in   (spi.spi_cs_n),
        .mosi_in   (spi.spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    state_t               state;
    op_t                  op;
    logic [4:0]           bit_cnt;
    logic [SHW-1:0]       shreg;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           tx_sr;
    logic [7:0]           rx_sr;
    logic                 load_pending;
    logic                 miso_q;
    logic                 oe_q;

    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;
    logic [7:0]           mem [0:DEPTH-1];

    // Values completed by the current rise (current bit appended)
    logic [7:0]           cmd_byte;
    logic [ADDR_BITS-1:0] addr_shift;
    logic [7:0]           wr_byte;
    logic [ADDR_BITS-1:0] addr_inc;

    assign cmd_byte   = {shreg[CMD_BITS-2:0], mosi_s};
    assign addr_shift = {shreg[ADDR_BITS-2:0], mosi_s};
    assign wr_byte    = {rx_sr[6:0], mosi_s};
    assign addr_inc   = addr + 1'b1;

    // Single-port byte array with registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Protocol FSM: cs_n high overrides everything and returns to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op           <= OP_READ;
            bit_cnt      <= '0;
            shreg        <= '0;
            addr         <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            load_pending <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            busy         <= 1'b0;
            wr_evt       <= 1'b0;
            wr_evt_addr  <= '0;
            wr_evt_data  <= '0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_wdata    <= '0;
        end else begin
            ram_we <= 1'b0;
            wr_evt <= 1'b0;
            busy   <= ~cs_n_s;
            if (cs_n_s) begin
                state        <= S_IDLE;
                oe_q         <= 1'b0;
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // CS just asserted; a rise landing in this same clk is bit 0
                        state   <= S_CMD;
                        oe_q    <= 1'b0;
                        bit_cnt <= '0;
                        if (sclk_rise) begin
                            shreg   <= {shreg[SHW-2:0], mosi_s};
                            bit_cnt <= 5'd1;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            shreg <= {shreg[SHW-2:0], mosi_s};
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                case (cmd_byte)
                                    CMD_READ: begin
                                        op    <= OP_READ;
                                        state <= S_ADDR;
                                    end
                                    CMD_WRITE: begin
                                        op    <= OP_WRITE;
                                        state <= S_ADDR;
                                    end
`ifdef SPI_RAM_TARGET_FAST_READ_EN
                                    CMD_FAST_READ: begin
                                        op    <= OP_FAST_READ;
                                        state <= S_ADDR;
                                    end
`else
                                    CMD_FAST_READ: state <= S_IGNORE;
`endif
                                    default: state <= S_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            shreg <= {shreg[SHW-2:0], mosi_s};
                            if (bit_cnt == ADDR_LAST) begin
                                // Upper address bits fall off the shift register (aliasing)
                                bit_cnt  <= '0;
                                addr     <= addr_shift;
                                ram_addr <= addr_shift;
                                case (op)
                                    OP_READ: begin
                                        state        <= S_RD_DATA;
                                        load_pending <= 1'b1;
                                    end
                                    OP_WRITE:     state <= S_WR_DATA;
                                    OP_FAST_READ: state <= S_DUMMY;
                                    default:      state <= S_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        // Array read was already launched with the address; just count
                        if (sclk_rise) begin
                            if (bit_cnt == DUMMY_LAST) begin
                                bit_cnt      <= '0;
                                state        <= S_RD_DATA;
                                load_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (sclk_fall) begin
                            oe_q <= 1'b1;
                            if (load_pending) begin
                                miso_q       <= ram_rdata[7];
                                tx_sr        <= {ram_rdata[6:0], 1'b0};
                                load_pending <= 1'b0;
                                bit_cnt      <= 5'd1;
                            end else begin
                                miso_q <= tx_sr[7];
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                                if (bit_cnt == BYTE_LAST) begin
                                    // bit0 now on the pin: fetch the next byte for the next fall
                                    bit_cnt      <= '0;
                                    addr         <= addr_inc;
                                    ram_addr     <= addr_inc;
                                    load_pending <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                end
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (sclk_rise) begin
                            rx_sr <= wr_byte;
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt     <= '0;
                                ram_we      <= 1'b1;
                                ram_addr    <= addr;
                                ram_wdata   <= wr_byte;
                                wr_evt      <= 1'b1;
                                wr_evt_addr <= addr;
                                wr_evt_data <= wr_byte;
                                addr        <= addr_inc;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        oe_q <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        oe_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_spi_ram_target.sv
// Bench for spi_ram_target: directed vector table, hand-written corner cases
// (partial write, reset mid-read, fast read) and random write/read traffic
// checked against a byte-array model of the serial RAM.
`timescale 1ns/1ps
module tb_spi_ram_target;
    import spi_mem_pkg::*;

    localparam int ADDR_BITS   = 12;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDR_BITS;
    localparam int HALF        = 4;   // sclk half period in clk cycles (sclk = clk/8)

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 busy;
    logic                 wr_evt;
    logic [ADDR_BITS-1:0] wr_evt_addr;
    logic [7:0]           wr_evt_data;
    logic [2:0]           dbg_state;

    spi_ram_target_if spi ();

    spi_ram_target #(.ADDR_BITS(ADDR_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi),
        .busy        (busy),
        .wr_evt      (wr_evt),
        .wr_evt_addr (wr_evt_addr),
        .wr_evt_data (wr_evt_data),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0]           ref_mem [DEPTH];
    logic [ADDR_BITS+7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every wr_evt must match the oldest expected (addr,data) pair
    always @(negedge clk) begin
        if (!rst && wr_evt === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_evt_unexpected: got addr %h data %h expected none",
                         wr_evt_addr, wr_evt_data);
            end else begin
                check("wr_evt", {12'h0, wr_evt_addr, wr_evt_data}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    // Model: bytes land at consecutive addresses modulo the array depth
    function automatic void model_write(input logic [23:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            int         idx;
            logic [7:0] b;
            idx = (int'(a) + i) % DEPTH;
            b   = d[8*(n-1-i) +: 8];
            ref_mem[idx] = b;
            exp_q.push_back({idx[ADDR_BITS-1:0], b});
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[23:0], ref_mem[(int'(a) + i) % DEPTH]};
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit: MISO/OE sampled just before the rising sclk edge
    task automatic xfer_bit(input logic tx, output logic rx, output logic oe);
        spi.spi_mosi = tx;
        wait_clk(HALF);
        rx = spi.spi_miso;
        oe = spi.spi_miso_oe;
        spi.spi_clk = 1'b1;
        wait_clk(HALF);
        spi.spi_clk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_any);
        logic b, o;
        oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(tx[i], b, o);
            rx[i]  = b;
            oe_any = oe_any | o;
        end
    endtask

    task automatic cs_begin();
        spi.spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(2);
        spi.spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        logic       o;
        xfer_byte(cmd, rx, o);
        xfer_byte(a[23:16], rx, o);
        xfer_byte(a[15:8], rx, o);
        xfer_byte(a[7:0], rx, o);
    endtask

    // Full transaction; rdata collects data-phase bytes, oe_any covers data phase only
    task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] a, input int n,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic oe_any);
        logic [7:0] rx;
        logic       o;
        rdata  = '0;
        oe_any = 1'b0;
        cs_begin();
        send_header(cmd, a);
        for (int i = 0; i < n; i++) begin
            xfer_byte(wdata[8*(n-1-i) +: 8], rx, o);
            rdata  = {rdata[23:0], rx};
            oe_any = oe_any | o;
        end
        cs_end();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_oe;
    } vec_t;

    vec_t vecs[10];

    typedef struct {
        logic [23:0] a;
        int          n;
    } wr_rec_t;
    wr_rec_t written[$];

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic        oe, o, b;
        logic [7:0]  rx;

        vecs[0] = '{"wr_0x10",      8'h02, 24'h000010, 2, 32'h0000A53C, 32'h0,        1'b0};
        vecs[1] = '{"rd_0x10",      8'h03, 24'h000010, 2, 32'h0,        32'h0000A53C, 1'b1};
        vecs[2] = '{"wr_wrap",      8'h02, 24'h000FFF, 2, 32'h00001122, 32'h0,        1'b0};
        vecs[3] = '{"rd_wrap",      8'h03, 24'h000FFF, 2, 32'h0,        32'h00001122, 1'b1};
        vecs[4] = '{"rd_000",       8'h03, 24'h000000, 1, 32'h0,        32'h00000022, 1'b1};
        vecs[5] = '{"wr_0x20",      8'h02, 24'h000020, 1, 32'h0000005A, 32'h0,        1'b0};
        vecs[6] = '{"wr_0x40",      8'h02, 24'h000040, 1, 32'h000000C7, 32'h0,        1'b0};
        vecs[7] = '{"unknown_cmd",  8'h9F, 24'h000010, 2, 32'h0000FFFF, 32'h0,        1'b0};
        vecs[8] = '{"rd_after_unk", 8'h03, 24'h000010, 2, 32'h0,        32'h0000A53C, 1'b1};
        vecs[9] = '{"rd_alias",     8'h03, 24'hABC010, 1, 32'h0,        32'h000000A5, 1'b1};

        spi.spi_clk  = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        rst = 1'b1;
        wait_clk(4);

        // Reset state
        check("rst_miso",        spi.spi_miso,    0);
        check("rst_oe",          spi.spi_miso_oe, 0);
        check("rst_busy",        busy,            0);
        check("rst_wr_evt",      wr_evt,          0);
        check("rst_wr_evt_addr", wr_evt_addr,     0);
        check("rst_wr_evt_data", wr_evt_data,     0);
        check("rst_state",       dbg_state,       0);
        rst = 1'b0;
        wait_clk(4);

        // Busy follows CS
        spi.spi_cs_n = 1'b0;
        wait_clk(SYNC_STAGES + 2);
        check("busy_cs_low", busy, 1);
        spi.spi_cs_n = 1'b1;
        wait_clk(8);

        foreach (vecs[i]) begin
            if (vecs[i].cmd == CMD_WRITE) model_write(vecs[i].addr, vecs[i].n, vecs[i].wdata);
            spi_txn(vecs[i].cmd, vecs[i].addr, vecs[i].n, vecs[i].wdata, rd, oe);
            check({vecs[i].name, "_oe"}, oe, vecs[i].exp_oe);
            if (vecs[i].cmd == CMD_READ) check({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
        end
        check("wr_evt_pending_table", exp_q.size(), 0);

        // Partial write byte: CS high after 5 bits of 0xFF at 0x20
        cs_begin();
        send_header(CMD_WRITE, 24'h000020);
        for (int i = 0; i < 5; i++) xfer_bit(1'b1, b, o);
        wait_clk(2);
        spi.spi_cs_n = 1'b1;
        wait_clk(SYNC_STAGES + 1);
        check("abort_busy",  busy,            0);
        check("abort_oe",    spi.spi_miso_oe, 0);
        check("abort_state", dbg_state,       0);
        wait_clk(8);
        spi_txn(CMD_READ, 24'h000020, 1, 32'h0, rd, oe);
        check("abort_mem_kept", rd, 32'h5A);

        // Reset in the middle of a read at 0x40
        cs_begin();
        send_header(CMD_READ, 24'h000040);
        rx = '0;
        for (int i = 7; i >= 4; i--) begin
            xfer_bit(1'b0, b, o);
            rx[i] = b;
        end
        check("midrd_oe", o, 1);
        check("midrd_hi_nibble", rx[7:4], 4'hC);
        rst = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_cs_n = 1'b1;
        wait_clk(2);
        check("midrst_oe",    spi.spi_miso_oe, 0);
        check("midrst_state", dbg_state,       0);
        check("midrst_busy",  busy,            0);
        rst = 1'b0;
        wait_clk(8);
        spi_txn(CMD_READ, 24'h000040, 1, 32'h0, rd, oe);
        check("post_rst_rd_0x40", rd, 32'hC7);

        // FAST READ at 0x010 with one dummy byte
        cs_begin();
        send_header(CMD_FAST_READ, 24'h000010);
        xfer_byte(8'h00, rx, o);
        check("fast_dummy_oe", o, 0);
        rd = '0;
        oe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            xfer_byte(8'h00, rx, o);
            rd = {rd[23:0], rx};
            oe = oe | o;
        end
        cs_end();
`ifdef SPI_RAM_TARGET_FAST_READ_EN
        check("fast_rd_oe",   oe, 1);
        check("fast_rd_data", rd, 32'h0000A53C);
`else
        check("fast_rd_disabled_oe", oe, 0);
`endif
        check("wr_evt_pending_hand", exp_q.size(), 0);

        // Random write/read traffic against the array model
        for (int k = 0; k < 24; k++) begin
            logic [23:0] a;
            logic [31:0] d;
            int          n, j;
            if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = 24'($urandom);
                n = $urandom_range(1, 4);
                d = $urandom;
                model_write(a, n, d);
                spi_txn(CMD_WRITE, a, n, d, rd, oe);
                check("rand_wr_oe", oe, 0);
                written.push_back('{a, n});
            end else begin
                j   = $urandom_range(0, written.size() - 1);
                exp = model_read(written[j].a, written[j].n);
                spi_txn(CMD_READ, written[j].a, written[j].n, 32'h0, rd, oe);
                check("rand_rd_oe", oe, 1);
                check("rand_rd_data", rd, exp);
            end
        end
        wait_clk(4);
        check("wr_evt_pending_final", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
